// File: rtl/operand_stage_pkg.sv
// Shared core definitions: datapath widths, ALU operation encoding and the
// ID/EX pipeline entry handed from the operand stage to the ALU.
package operand_stage_pkg;

  localparam int XLen  = 32;
  localparam int NRegs = 32;
  localparam int AddrW = $clog2(NRegs);
  localparam int NOps  = 5;
  localparam int OpW   = $clog2(NOps);

  typedef enum logic [OpW-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic signed [XLen-1:0] a;
    logic signed [XLen-1:0] b;
    alu_op_e                alu_control;
    logic [AddrW-1:0]       rd;
    logic                   reg_write;
  } id_ex_t;

endpackage

// File: rtl/operand_stage_regfile.sv
// Integer register file: two combinational read ports with same-cycle
// write-back bypass, one write port, x0 hardwired to zero.
module operand_stage_regfile #(
  parameter int XLen  = operand_stage_pkg::XLen,
  parameter int NRegs = operand_stage_pkg::NRegs
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [$clog2(NRegs)-1:0] rs1_addr_i,
  input  logic [$clog2(NRegs)-1:0] rs2_addr_i,
  output logic [XLen-1:0]          rs1_data_o,
  output logic [XLen-1:0]          rs2_data_o,
  input  logic                     wb_en_i,
  input  logic [$clog2(NRegs)-1:0] wb_addr_i,
  input  logic [XLen-1:0]          wb_data_i
);

  localparam int AddrW = $clog2(NRegs);

  logic [XLen-1:0] mem [NRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NRegs; i++) mem[i] <= '0;
    end else if (wb_en_i && (wb_addr_i != '0)) begin
      mem[wb_addr_i] <= wb_data_i;
    end
  end

  // Bypass lets an instruction captured in the write-back cycle see the new value.
  assign rs1_data_o = (rs1_addr_i == '0) ? '0 :
                      (wb_en_i && (wb_addr_i == rs1_addr_i)) ? wb_data_i : mem[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == '0) ? '0 :
                      (wb_en_i && (wb_addr_i == rs2_addr_i)) ? wb_data_i : mem[rs2_addr_i];

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register read with bypass, operand B
// select, and a one-entry ID/EX register with handshake, flush and refresh.
module operand_stage #(
  parameter int XLen  = operand_stage_pkg::XLen,
  parameter int NRegs = operand_stage_pkg::NRegs,
  parameter int NOps  = operand_stage_pkg::NOps
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [$clog2(NRegs)-1:0] rs1_addr_i,
  input  logic [$clog2(NRegs)-1:0] rs2_addr_i,
  input  logic [$clog2(NRegs)-1:0] rd_addr_i,
  input  logic [XLen-1:0]          imm_i,
  input  logic                     use_imm_i,
  input  logic [$clog2(NOps)-1:0]  alu_control_i,
  input  logic                     reg_write_i,
  input  logic                     flush_i,
  input  logic                     wb_en_i,
  input  logic [$clog2(NRegs)-1:0] wb_addr_i,
  input  logic [XLen-1:0]          wb_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [XLen-1:0]          a_o,
  output logic [XLen-1:0]          b_o,
  output logic [$clog2(NOps)-1:0]  alu_control_o,
  output logic [$clog2(NRegs)-1:0] rd_addr_o,
  output logic                     reg_write_o
);

  import operand_stage_pkg::*;

  localparam int AddrW = $clog2(NRegs);

  logic [XLen-1:0]  rs1_data, rs2_data;
  logic [XLen-1:0]  a_p0, b_p0;
  logic             in_fire, out_fire;
  id_ex_t           ex_p1;
  logic             vld_p1;
  logic [AddrW-1:0] rs1_p1, rs2_p1;
  logic             use_imm_p1;
  logic             wb_live, refresh_a, refresh_b;

  operand_stage_regfile #(
    .XLen  (XLen),
    .NRegs (NRegs)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i)
  );

  // p0: operand selection and handshake
  assign a_p0       = rs1_data;
  assign b_p0       = use_imm_i ? imm_i : rs2_data;
  assign in_ready_o = !vld_p1 || out_ready_i;
  assign in_fire    = in_valid_i && in_ready_o && !flush_i;
  assign out_fire   = vld_p1 && out_ready_i;

  // Refresh keeps a stalled entry coherent with write-backs that land after capture.
  assign wb_live   = vld_p1 && !in_fire && !flush_i && wb_en_i && (wb_addr_i != '0);
  assign refresh_a = wb_live && (wb_addr_i == rs1_p1);
  assign refresh_b = wb_live && (wb_addr_i == rs2_p1) && !use_imm_p1;

  // p1: ID/EX pipeline register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1     <= 1'b0;
      ex_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      use_imm_p1 <= 1'b0;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (in_fire) begin
      vld_p1            <= 1'b1;
      ex_p1.a           <= a_p0;
      ex_p1.b           <= b_p0;
      ex_p1.alu_control <= alu_op_e'(alu_control_i);
      ex_p1.rd          <= rd_addr_i;
      ex_p1.reg_write   <= reg_write_i;
      rs1_p1            <= rs1_addr_i;
      rs2_p1            <= rs2_addr_i;
      use_imm_p1        <= use_imm_i;
    end else begin
      if (out_fire) vld_p1 <= 1'b0;
      if (refresh_a) ex_p1.a <= wb_data_i;
      if (refresh_b) ex_p1.b <= wb_data_i;
    end
  end

  assign out_valid_o   = vld_p1;
  assign a_o           = ex_p1.a;
  assign b_o           = ex_p1.b;
  assign alu_control_o = ex_p1.alu_control;
  assign rd_addr_o     = ex_p1.rd;
  assign reg_write_o   = vld_p1 && ex_p1.reg_write;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: a reference register file and a
// one-entry model track expected ID/EX contents cycle by cycle.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid, in_ready, use_imm, reg_write, flush, wb_en;
  logic [4:0]  rs1, rs2, rd, wb_addr;
  logic [31:0] imm, wb_data;
  logic [2:0]  alu_ctl;
  logic        out_valid, out_ready, reg_write_o;
  logic [31:0] a_o, b_o;
  logic [2:0]  alu_control_o;
  logic [4:0]  rd_addr_o;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic [4:0]  rs1, rs2;
    logic        ui;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  bit          mvalid;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  operand_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .rs1_addr_i    (rs1),
    .rs2_addr_i    (rs2),
    .rd_addr_i     (rd),
    .imm_i         (imm),
    .use_imm_i     (use_imm),
    .alu_control_i (alu_ctl),
    .reg_write_i   (reg_write),
    .flush_i       (flush),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .a_o           (a_o),
    .b_o           (b_o),
    .alu_control_o (alu_control_o),
    .rd_addr_o     (rd_addr_o),
    .reg_write_o   (reg_write_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return mregs[r];
  endfunction

  task automatic idle();
    in_valid = 0; rs1 = 0; rs2 = 0; rd = 0; imm = 0; use_imm = 0;
    alu_ctl = 0; reg_write = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic model_reset();
    q.delete();
    mvalid = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
  endtask

  // One clock: check at the falling edge, advance the model, then step past the rising edge.
  task automatic step();
    exp_t e;
    bit   fire;
    @(negedge clk);
    chk("in_ready", in_ready, !mvalid || out_ready);
    chk("out_valid", out_valid, mvalid);
    if (!mvalid) chk("rw_when_invalid", reg_write_o, 0);
    if (mvalid && q.size() != 0) begin
      chk("a", a_o, q[0].a);
      chk("b", b_o, q[0].b);
      chk("alu", alu_control_o, q[0].alu);
      chk("rd", rd_addr_o, q[0].rd);
      chk("rw", reg_write_o, q[0].rw);
    end
    if (mvalid && out_ready && q.size() != 0) void'(q.pop_front());
    fire = in_valid && (!mvalid || out_ready) && !flush;
    if (flush) q.delete();
    else if (fire) begin
      e.a = mread(rs1);
      e.b = use_imm ? imm : mread(rs2);
      e.alu = alu_ctl; e.rd = rd; e.rw = reg_write;
      e.rs1 = rs1; e.rs2 = rs2; e.ui = use_imm;
      q.push_back(e);
    end else if (mvalid && !out_ready && wb_en && wb_addr != 0 && q.size() != 0) begin
      if (wb_addr == q[0].rs1) q[0].a = wb_data;
      if (wb_addr == q[0].rs2 && !q[0].ui) q[0].b = wb_data;
    end
    mvalid = flush ? 1'b0 : fire ? 1'b1 : (mvalid && out_ready) ? 1'b0 : mvalid;
    if (wb_en && wb_addr != 0) mregs[wb_addr] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic ui,
                       input logic [31:0] im, input logic [2:0] op, input logic [4:0] d,
                       input logic w);
    in_valid = 1; rs1 = r1; rs2 = r2; use_imm = ui; imm = im;
    alu_ctl = op; rd = d; reg_write = w;
  endtask

  task automatic wb(input logic [4:0] ad, input logic [31:0] d);
    wb_en = 1; wb_addr = ad; wb_data = d;
  endtask

  initial begin
    idle();
    out_ready = 1;
    rst_ni = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);
    chk("rst_alu", alu_control_o, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_rw", reg_write_o, 0);
    @(posedge clk); #1;
    rst_ni = 1;

    // x0 write ignored, x0 reads zero
    idle(); wb(5'd0, 32'hDEAD_BEEF); issue(5'd0, 5'd0, 0, 0, 3'd0, 5'd1, 1);
    step();
    idle(); step();

    // same-cycle bypass
    idle(); wb(5'd5, 32'h1234_5678); issue(5'd5, 5'd5, 0, 0, 3'd1, 5'd2, 1);
    step();
    idle(); step();

    // immediate select
    idle(); wb(5'd3, 32'd7); step();
    idle(); issue(5'd3, 5'd0, 1, 32'hFFFF_FFFC, 3'd2, 5'd9, 1); step();
    idle(); step();
    chk("imm_done_valid", out_valid, 0);

    // stall with refresh of held rs1/rs2
    idle(); wb(5'd4, 32'd1); step();
    idle(); out_ready = 0; issue(5'd4, 5'd4, 0, 0, 3'd3, 5'd6, 1); step();
    idle(); wb(5'd4, 32'h55); issue(5'd7, 5'd8, 0, 0, 3'd0, 5'd7, 1); step();
    chk("stall_a", a_o, 32'h55);
    chk("stall_ready", in_ready, 0);
    idle(); step();
    out_ready = 1; step();
    idle(); step();

    // flush beats a simultaneous capture
    idle(); out_ready = 0; issue(5'd5, 5'd3, 0, 0, 3'd4, 5'd10, 1); step();
    out_ready = 1; issue(5'd3, 5'd3, 0, 0, 3'd1, 5'd11, 1); flush = 1; step();
    idle();
    chk("flush_valid", out_valid, 0);
    chk("flush_rw", reg_write_o, 0);
    step();

    // streaming: back-to-back, then with toggling ready
    for (int i = 0; i < 8; i++) begin
      idle();
      issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, 3'($urandom_range(0, 4)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1)) wb(5'($urandom_range(0, 31)), $urandom);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      idle();
      out_ready = i[0];
      issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $urandom, 3'($urandom_range(0, 4)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1)) wb(5'($urandom_range(0, 31)), $urandom);
      step();
    end
    idle(); out_ready = 1;
    repeat (3) step();
    chk("stream_drained", q.size(), 0);

    // asynchronous reset mid-operation
    idle(); out_ready = 0; wb(5'd12, 32'hCAFE_F00D); issue(5'd5, 5'd5, 0, 0, 3'd2, 5'd3, 1); step();
    idle();
    #2 rst_ni = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rw", reg_write_o, 0);
    chk("async_rst_a", a_o, 0);
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1; out_ready = 1;
    issue(5'd5, 5'd12, 0, 0, 3'd0, 5'd1, 1); step();
    idle(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Decode-to-execute operand stage directly upstream of the ALU.
- Holds the integer register file. Reads rs1/rs2 with write-back bypass and selects immediate or rs2 for operand B.
- Registers the ALU inputs and control into a one-entry ID/EX pipeline register, with a valid/ready handshake, flush, and refresh of held operands.
- Outputs a_o/b_o/alu_control_o connect straight to the ALU's a_i/b_i/alu_control_i.

Parameters:
- XLen, 32, data width; must match the ALU.
- NRegs, 32, number of architectural registers; register 0 reads as zero.
- NOps, 5, number of ALU operations; alu_control width is $clog2(NOps).
- AddrW (localparam), $clog2(NRegs), register address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  decode presents an instruction.
- in_ready_o  out  1  stage can accept an instruction this cycle.
- rs1_addr_i  in  AddrW  source register 1.
- rs2_addr_i  in  AddrW  source register 2.
- rd_addr_i  in  AddrW  destination register.
- imm_i  in  XLen  sign-extended immediate.
- use_imm_i  in  1  1: B = imm_i; 0: B = rs2 value.
- alu_control_i  in  $clog2(NOps)  ALU operation select.
- reg_write_i  in  1  instruction writes rd.
- flush_i  in  1  discard the held entry and block capture this cycle.
- wb_en_i  in  1  write-back enable.
- wb_addr_i  in  AddrW  write-back register.
- wb_data_i  in  XLen  write-back data.
- out_valid_o  out  1  held entry is valid toward execute.
- out_ready_i  in  1  execute consumes the entry.
- a_o  out  XLen  ALU operand A.
- b_o  out  XLen  ALU operand B.
- alu_control_o  out  $clog2(NOps)  registered ALU operation.
- rd_addr_o  out  AddrW  registered destination.
- reg_write_o  out  1  registered write enable; forced 0 when the entry is invalid.

Behaviour:
- **Reset** (rst_ni low, asynchronous):
  - out_valid_o, a_o, b_o, alu_control_o, rd_addr_o, reg_write_o all go to 0.
  - All register-file entries go to 0.
  - Internal held rs1/rs2 addresses and held use_imm go to 0.
- **Register file:**
  - Write on the clock edge when wb_en_i=1 and wb_addr_i!=0.
  - Writes to register 0 are ignored.
  - Reads are combinational.
- **Read value for a source rs:**
  - rs==0 gives 0.
  - Otherwise, if wb_en_i=1 and wb_addr_i==rs, gives wb_data_i (same-cycle bypass).
  - Otherwise gives the stored register value.
- **Operand selection:**
  - A = read(rs1_addr_i).
  - B = use_imm_i ? imm_i : read(rs2_addr_i).
- **Handshake:**
  - in_ready_o = !out_valid_o || out_ready_i. This is combinational and does not depend on in_valid_i.
  - in_fire = in_valid_i && in_ready_o && !flush_i.
  - out_fire = out_valid_o && out_ready_i.
- **Next out_valid_o:**
  - flush_i gives 0.
  - Otherwise, in_fire gives 1.
  - Otherwise, out_fire gives 0.
  - Otherwise, out_valid_o holds.
- **On in_fire:**
  - Capture A, B, alu_control_i, rd_addr_i, reg_write_i, rs1_addr_i, rs2_addr_i, use_imm_i.
  - Latency: input to out_valid_o is one cycle.
  - Back-to-back: throughput is 1 per cycle while out_ready_i=1.
- **Held-operand refresh:**
  - Applies while out_valid_o=1 and no in_fire, and wb_en_i=1 with wb_addr_i!=0.
  - If wb_addr_i == held rs1, a_o <= wb_data_i.
  - If wb_addr_i == held rs2 and held use_imm=0, b_o <= wb_data_i.
  - Both may update in the same cycle.
  - This removes stale operands while execute stalls.
- **Flush:**
  - Takes priority over in_fire and refresh.
  - Data fields may keep their old values; reg_write_o must read 0 whenever out_valid_o=0.
- **Stall:** with out_valid_o=1 and out_ready_i=0, all outputs hold except for refresh.
- **Simultaneous write-back and capture:** the bypass supplies the new value; no one-cycle hazard.
- **Reset mid-operation:** the held entry is lost, out_valid_o goes to 0 immediately, and register contents are zeroed.

Decomposition:
- **Shared package (e.g. core_pkg)**, containing:
  - XLen, NRegs, AddrW.
  - NOps and the alu_op_e enum (width $clog2(NOps)) used by both the ALU and this stage.
  - The id_ex_t struct: a, b, alu_control, rd, reg_write.
- **One sub-module, regfile**, with:
  - 2 read ports and 1 write port.
  - x0 hardwired to zero.
  - Internal write-back bypass.
  - The same clock and reset as this stage.
- The operand_stage top holds operand muxing, the handshake, the pipeline register and the refresh logic.

Test Plan:
- **Reset and x0:**
  - Stimulus: release reset; wb_en=1, wb_addr=0, wb_data=0xDEAD_BEEF; then issue rs1=0, rs2=0, use_imm=0.
  - Response: a_o=0, b_o=0, out_valid_o=1 one cycle after in_valid.
- **Bypass:**
  - Stimulus: in the same cycle, wb x5<=0x1234_5678 and issue rs1=5, rs2=5, use_imm=0.
  - Response: next cycle a_o=b_o=0x1234_5678.
- **Immediate select:**
  - Stimulus: x3=7; issue rs1=3, use_imm=1, imm=0xFFFF_FFFC, alu_control=2, rd=9, reg_write=1.
  - Response: a_o=7, b_o=0xFFFF_FFFC, alu_control_o=2, rd_addr_o=9, reg_write_o=1.
- **Stall and refresh:**
  - Stimulus: capture rs1=4 (x4=1) with out_ready_i=0; next cycle wb x4<=0x55.
  - Response: a_o becomes 0x55; in_ready_o=0 for the whole stall; the entry is consumed once when out_ready_i=1.
- **Flush priority:**
  - Stimulus: out_valid_o=1; assert flush_i together with in_valid_i=1 and in_ready_o=1.
  - Response: next cycle out_valid_o=0, reg_write_o=0, and the new instruction is not captured.
- **Streaming:**
  - Stimulus: 8 back-to-back instructions with out_ready_i=1, then out_ready_i toggling every cycle.
  - Response: every instruction is delivered exactly once and in order; no drops or duplicates, checked against a scoreboard.
